// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its transmitter sibling.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } uart_rx_state_t;

    function automatic bit data_bits_ok(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous line, with a selectable reset level.
module uart_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_receiver_cfg.sv
// UART receiver with configurable data width, parity and stop bits; delivers words on valid/ready.
//
// state         | meaning
// --------------+---------------------------------------------------------------
// ST_IDLE       | line idle, waiting for a low level on rx_s
// ST_START      | timing to mid start bit, rejecting glitches
// ST_DATA       | sampling DATA_BITS bits mid-bit, LSB first
// ST_PARITY     | sampling the parity bit
// ST_STOP       | sampling STOP_BITS stop bits, commit on the last one
// ST_BREAK_WAIT | last stop bit was low; wait for the line to return high
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clock,
    input  logic                 i_rst_n,
    input  logic                 i_RX_Serial,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_RX_Valid,
    input  logic                 i_RX_Ready,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_RX_Busy
);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("uart_receiver_cfg: CLKS_PER_BIT must be >= 4");
    end
    if (!data_bits_ok(DATA_BITS)) begin : g_chk_db
        $error("uart_receiver_cfg: DATA_BITS must be 5..9");
    end
    if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_chk_par
        $error("uart_receiver_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
        $error("uart_receiver_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] IDX_LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] IDX_LAST_STOP  = 4'(STOP_BITS - 1);

    logic rx_s;

    uart_bit_sync #(.RESET_VAL(1'b1)) u_sync (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .i_async (i_RX_Serial),
        .o_sync  (rx_s)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pend_par_q, pend_par_d;
    logic                 pend_frm_q, pend_frm_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 commit;
    logic                 bit_done;
    logic                 exp_par;

    assign bit_done = (cnt_q == CNT_LAST);
    assign exp_par  = (PARITY == PARITY_ODD) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        pend_par_d = pend_par_q;
        pend_frm_d = pend_frm_q;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    cnt_d      = '0;
                    idx_d      = '0;
                    pend_par_d = 1'b0;
                    pend_frm_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                    if (rx_s != exp_par) begin
                        pend_par_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        pend_frm_d = 1'b1;
                    end
                    if (idx_q == IDX_LAST_STOP) begin
                        commit  = 1'b1;
                        idx_d   = '0;
                        // Leaving at mid stop bit lets a back-to-back start edge be seen.
                        state_d = rx_s ? ST_IDLE : ST_BREAK_WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rx_valid_q & ~i_RX_Ready;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (commit) begin
            if (!rx_valid_q || i_RX_Ready) begin
                rx_byte_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = pend_par_d;
                frame_err_d  = pend_frm_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            pend_par_q   <= 1'b0;
            pend_frm_q   <= 1'b0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            pend_par_q   <= pend_par_d;
            pend_frm_q   <= pend_frm_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_RX_Byte    = rx_byte_q;
    assign o_RX_Valid   = rx_valid_q;
    assign o_Parity_Err = parity_err_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Overrun    = overrun_q;
    assign o_RX_Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Directed bench for uart_receiver_cfg using 8N1, 8E1 and 7O2 instances on one clock.
module tb_uart_receiver_cfg;

    localparam int CPB = 87;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst_n = 1'b0;
    logic rst_o = 1'b0;

    logic rx_n = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
    logic rdy_n = 1'b1, rdy_e = 1'b1, rdy_o = 1'b1;
    logic [7:0] byte_n, byte_e;
    logic [6:0] byte_o;
    logic v_n, v_e, v_o, pe_n, pe_e, pe_o, fe_n, fe_e, fe_o;
    logic ov_n, ov_e, ov_o, busy_n, busy_e, busy_o;

    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .i_clock(clk), .i_rst_n(rst_n), .i_RX_Serial(rx_n), .o_RX_Byte(byte_n),
        .o_RX_Valid(v_n), .i_RX_Ready(rdy_n), .o_Parity_Err(pe_n), .o_Frame_Err(fe_n),
        .o_Overrun(ov_n), .o_RX_Busy(busy_n));

    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .i_clock(clk), .i_rst_n(rst_n), .i_RX_Serial(rx_e), .o_RX_Byte(byte_e),
        .o_RX_Valid(v_e), .i_RX_Ready(rdy_e), .o_Parity_Err(pe_e), .o_Frame_Err(fe_e),
        .o_Overrun(ov_e), .o_RX_Busy(busy_e));

    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_o (
        .i_clock(clk), .i_rst_n(rst_o), .i_RX_Serial(rx_o), .o_RX_Byte(byte_o),
        .o_RX_Valid(v_o), .i_RX_Ready(rdy_o), .o_Parity_Err(pe_o), .o_Frame_Err(fe_o),
        .o_Overrun(ov_o), .o_RX_Busy(busy_o));

    // Transfers captured as {parity_err, frame_err, 9-bit word}.
    logic [10:0] q_n[$], q_e[$], q_o[$];
    int vcyc_n = 0, ovc_n = 0, ovc_e = 0, ovc_o = 0;

    always @(negedge clk) begin
        if (v_n) vcyc_n++;
        if (v_n && rdy_n) q_n.push_back({pe_n, fe_n, 1'b0, byte_n});
        if (v_e && rdy_e) q_e.push_back({pe_e, fe_e, 1'b0, byte_e});
        if (v_o && rdy_o) q_o.push_back({pe_o, fe_o, 2'b00, byte_o});
        if (ov_n) ovc_n++;
        if (ov_e) ovc_e++;
        if (ov_o) ovc_o++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        case (which)
            0:       rx_n = b;
            1:       rx_e = b;
            default: rx_o = b;
        endcase
        repeat (CPB) @(negedge clk);
    endtask

    // which: 0 = 8N1, 1 = 8E1, 2 = 7O2; par_force < 0 sends the correct parity bit.
    task automatic send_word(input int which, input logic [8:0] data, input int par_force,
                             input logic s1, input logic s2);
        int nb;
        logic pb;
        nb = (which == 2) ? 7 : 8;
        pb = 1'b0;
        drive_bit(which, 1'b0);
        for (int i = 0; i < nb; i++) begin
            drive_bit(which, data[i]);
            pb = pb ^ data[i];
        end
        if (which != 0) begin
            if (which == 2) pb = ~pb;
            if (par_force >= 0) pb = par_force[0];
            drive_bit(which, pb);
        end
        drive_bit(which, s1);
        if (which == 2) drive_bit(which, s2);
    endtask

    task automatic get_word(input int which, output logic [10:0] w, output bit got);
        int sz;
        got = 1'b0;
        w   = '0;
        for (int i = 0; i < 400; i++) begin
            sz = (which == 0) ? q_n.size() : (which == 1) ? q_e.size() : q_o.size();
            if (sz > 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            case (which)
                0:       w = q_n.pop_front();
                1:       w = q_e.pop_front();
                default: w = q_o.pop_front();
            endcase
        end
    endtask

    typedef struct {
        int         which;
        logic [8:0] data;
        int         par_force;
        logic       s1;
        logic       s2;
        logic [8:0] exp_byte;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] w;
        bit got;
        int v0, ov0, rise, fall;

        vecs[0]  = '{0, 9'h000, -1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h0FF, -1, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h081, -1, 1'b1, 1'b1, 9'h081, 1'b0, 1'b0};
        vecs[3]  = '{1, 9'h0CD,  0, 1'b1, 1'b1, 9'h0CD, 1'b1, 1'b0};
        vecs[4]  = '{1, 9'h0CD,  1, 1'b1, 1'b1, 9'h0CD, 1'b0, 1'b0};
        vecs[5]  = '{1, 9'h000, -1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h003,  1, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
        vecs[7]  = '{2, 9'h041, -1, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
        vecs[8]  = '{2, 9'h07F,  1, 1'b1, 1'b1, 9'h07F, 1'b1, 1'b0};
        vecs[9]  = '{2, 9'h02A, -1, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};
        vecs[10] = '{2, 9'h015, -1, 1'b1, 1'b0, 9'h015, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte", byte_n, 0);
        check("rst_valid", v_n, 0);
        check("rst_perr", pe_n, 0);
        check("rst_ferr", fe_n, 0);
        check("rst_ovr", ov_n, 0);
        check("rst_busy", busy_n, 0);
        rst_n = 1'b1;
        rst_o = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 0x3F, valid lasts exactly one cycle with ready high
        v0 = vcyc_n;
        send_word(0, 9'h03F, -1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        get_word(0, w, got);
        check("n3f_got", got, 1);
        check("n3f_byte", w[8:0], 9'h03F);
        check("n3f_err", w[10:9], 2'b00);
        check("n3f_vcyc", vcyc_n - v0, 1);

        for (int i = 0; i < 11; i++) begin
            send_word(vecs[i].which, vecs[i].data, vecs[i].par_force, vecs[i].s1, vecs[i].s2);
            drive_bit(vecs[i].which, 1'b1);
            drive_bit(vecs[i].which, 1'b1);
            get_word(vecs[i].which, w, got);
            check($sformatf("vec%0d_got", i), got, 1);
            check($sformatf("vec%0d_byte", i), w[8:0], vecs[i].exp_byte);
            check($sformatf("vec%0d_perr", i), w[10], vecs[i].exp_pe);
            check($sformatf("vec%0d_ferr", i), w[9], vecs[i].exp_fe);
        end

        // Break: 0x00 with low stop, line low 3 more bit times, then 0x55
        send_word(0, 9'h000, -1, 1'b0, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check("brk_busy", busy_n, 1);
        check("brk_one_word", q_n.size(), 1);
        get_word(0, w, got);
        check("brk_byte", w[8:0], 9'h000);
        check("brk_ferr", w[9], 1);
        check("brk_perr", w[10], 0);
        drive_bit(0, 1'b1);
        send_word(0, 9'h055, -1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        get_word(0, w, got);
        check("brk_next_got", got, 1);
        check("brk_next_byte", w[8:0], 9'h055);
        check("brk_next_err", w[10:9], 2'b00);

        // Glitch: 20-clock low pulse on an idle line
        repeat (2 * CPB) @(negedge clk);
        v0 = vcyc_n;
        rise = -1;
        fall = -1;
        for (int i = 0; i < 150; i++) begin
            if (i == 0)  rx_n = 1'b0;
            if (i == 20) rx_n = 1'b1;
            @(negedge clk);
            if (busy_n && rise < 0) rise = i;
            if (!busy_n && rise >= 0 && fall < 0) fall = i;
        end
        check("glitch_busy_rose", (rise >= 0), 1);
        check("glitch_busy_fell", (fall >= 0) && (fall - rise <= CPB / 2 + 3), 1);
        check("glitch_no_valid", vcyc_n - v0, 0);

        // Overrun: ready low, two back-to-back words
        @(posedge clk); #1 rdy_n = 1'b0;
        ov0 = ovc_n;
        send_word(0, 9'h0A5, -1, 1'b1, 1'b1);
        send_word(0, 9'h05A, -1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_byte_held", byte_n, 8'hA5);
        check("ovr_valid_held", v_n, 1);
        check("ovr_pulses", ovc_n - ov0, 1);
        @(posedge clk); #1 rdy_n = 1'b1;
        repeat (5) @(negedge clk);
        check("ovr_xfer_count", q_n.size(), 1);
        get_word(0, w, got);
        check("ovr_xfer_byte", w[8:0], 9'h0A5);
        check("ovr_valid_after", v_n, 0);

        // 7O2: hold a word with parity error, then reset mid data bit 3
        @(posedge clk); #1 rdy_o = 1'b0;
        send_word(2, 9'h02A, 1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("o_held_valid", v_o, 1);
        check("o_held_perr", pe_o, 1);
        check("o_held_byte", byte_o, 7'h2A);
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b0);
        rx_o = 1'b0;
        repeat (40) @(negedge clk);
        rst_o = 1'b0;
        repeat (2) @(negedge clk);
        check("orst_byte", byte_o, 0);
        check("orst_valid", v_o, 0);
        check("orst_perr", pe_o, 0);
        check("orst_ferr", fe_o, 0);
        check("orst_ovr", ov_o, 0);
        check("orst_busy", busy_o, 0);
        rx_o = 1'b1;
        repeat (3) @(negedge clk);
        rst_o = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("orst_no_partial", q_o.size(), 0);
        check("orst_valid_idle", v_o, 0);
        @(posedge clk); #1 rdy_o = 1'b1;
        send_word(2, 9'h041, -1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        get_word(2, w, got);
        check("orst_41_got", got, 1);
        check("orst_41_byte", w[8:0], 9'h041);
        check("orst_41_err", w[10:9], 2'b00);
        check("no_stray_ovr", ovc_e + ovc_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
